// File: rtl/fpadd_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
package fpadd_pkg;

  localparam int unsigned FP_W              = 32;
  localparam logic [31:0] FP_QNAN           = 32'h7FC0_0000;
  localparam int unsigned FPADD_TIMEOUT_DEF = 320;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Operand pair handed to the shared adder.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

endpackage

// File: rtl/fpadd_sched_rr_pick.sv
// Combinational round-robin picker: first request at or above the pointer, with wrap.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant_c,
  output logic [IW-1:0]   o_idx_c,
  output logic            o_any_c
);

  int unsigned   w_pos;
  logic [IW-1:0] w_cand;
  logic          w_found;

  // Scan NREQ positions starting at the pointer; the first set request wins.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = |i_req;
    w_found   = 1'b0;
    w_pos     = 0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= NREQ) begin
        w_pos = w_pos - NREQ;
      end
      w_cand = IW'(w_pos);
      if (!w_found && i_req[w_cand]) begin
        w_found           = 1'b1;
        o_grant_c[w_cand] = 1'b1;
        o_idx_c           = w_cand;
      end
    end
  end

endmodule

// File: rtl/fpadd_sched.sv
// Round-robin scheduler in front of one shared multi-cycle fp adder, with a done watchdog.
module fpadd_sched
  import fpadd_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = FPADD_TIMEOUT_DEF,
  localparam int unsigned IW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IW-1:0]        resp_id,
  output logic [FP_W-1:0]      resp_sum,
  output logic                 resp_err,
  output logic                 add_start,
  output logic [FP_W-1:0]      add_a,
  output logic [FP_W-1:0]      add_b,
  input  logic [FP_W-1:0]      add_sum,
  input  logic                 add_done
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  sched_state_t              r_state, w_state_nxt;
  logic [IW-1:0]             r_ptr, w_ptr_nxt;
  logic [IW-1:0]             r_owner, w_owner_nxt;
  fp_pair_t                  r_op, w_op_nxt;
  logic [FP_W-1:0]           r_sum, w_sum_nxt;
  logic                      r_err, w_err_nxt;
  logic [CW-1:0]             r_cnt, w_cnt_nxt;
  logic                      r_start;
  logic                      r_resp;
  logic [NREQ-1:0]           w_grant;
  logic [IW-1:0]             w_idx;
  logic                      w_any;
  logic [NREQ-1:0][FP_W-1:0] w_a_vec;
  logic [NREQ-1:0][FP_W-1:0] w_b_vec;

  assign w_a_vec = req_a;
  assign w_b_vec = req_b;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  // Next-state, datapath next values and the combinational accept.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_op_nxt    = r_op;
    w_sum_nxt   = r_sum;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    req_ready   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready   = reset ? '0 : w_grant;
          w_op_nxt.a  = w_a_vec[w_idx];
          w_op_nxt.b  = w_b_vec[w_idx];
          w_owner_nxt = w_idx;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A real completion beats a watchdog expiry in the same cycle.
        if (add_done) begin
          w_sum_nxt   = add_sum;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_sum_nxt   = FP_QNAN;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_ptr_nxt   = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered strobes; strobes are decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_op    <= '0;
      r_sum   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_op    <= w_op_nxt;
      r_sum   <= w_sum_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= (w_state_nxt == ST_ISSUE);
      r_resp  <= (w_state_nxt == ST_RESP);
    end
  end

  assign add_start  = r_start;
  assign add_a      = r_op.a;
  assign add_b      = r_op.b;
  assign resp_valid = r_resp;
  assign resp_id    = r_owner;
  assign resp_sum   = r_sum;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_fpadd_sched.sv
// Bench for fpadd_sched: behavioural adder, transaction-timeline model and directed scenarios.
`timescale 1ns/1ps
module tb_fpadd_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 320;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0][31:0] req_a = '0;
  logic [NREQ-1:0][31:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [1:0]            resp_id;
  logic [31:0]           resp_sum;
  logic                  resp_err;
  logic                  add_start;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_sum_m = 32'hDEAD_BEEF;
  logic                  add_done_m = 1'b1;

  int checks = 0;
  int errors = 0;

  fpadd_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_err   (resp_err),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum_m),
    .add_done   (add_done_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed IEEE sums for the directed pairs; other pairs get an arbitrary tag.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h4040_0000;
      64'h00000000_C0A00000: return 32'hC0A0_0000;
      64'h7F800000_3F800000: return 32'h7F80_0000;
      default:               return a + b;
    endcase
  endfunction

  // ---------------- adder model: done drops at start, rises a_lat cycles after the start cycle
  int          cyc = 0;
  int          a_start_cyc = 0;
  int          a_lat = 3;
  bit          a_stuck = 1'b0;
  bit          a_busy = 1'b0;
  logic        s_start = 1'b0;
  logic [31:0] s_a = '0, s_b = '0, p_a = '0, p_b = '0;

  always @(negedge clk) begin
    s_start <= add_start;
    s_a     <= add_a;
    s_b     <= add_b;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_start === 1'b1) begin
      a_busy      <= 1'b1;
      a_start_cyc <= cyc;
      add_done_m  <= 1'b0;
      p_a         <= s_a;
      p_b         <= s_b;
    end else if (a_busy && !a_stuck && (cyc - a_start_cyc) == a_lat - 1) begin
      add_done_m <= 1'b1;
      add_sum_m  <= fadd(p_a, p_b);
      a_busy     <= 1'b0;
    end
  end

  // ---------------- transaction model and per-cycle compare
  bit              m_busy = 1'b0;
  bit              m_pend = 1'b0;
  bit              m_err = 1'b0;
  int              m_age = 0;
  int              m_owner = 0;
  int              m_ptr = 0;
  logic [31:0]     m_a = '0, m_b = '0, m_sum = '0;
  logic [NREQ-1:0] m_g;
  int              ready_cnt[NREQ] = '{default: 0};
  int              start_cnt = 0;
  int              q_id[$];
  logic [31:0]     q_sum[$];
  bit              q_err[$];
  int              q_lat[$];

  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) begin
        g[(ptr + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_ptr  = 0;
      chk("rst_req_ready",  32'(req_ready),  32'(0));
      chk("rst_resp_valid", 32'(resp_valid), 32'(0));
      chk("rst_add_start",  32'(add_start),  32'(0));
      chk("rst_add_a",      add_a,           32'(0));
    end else begin
      for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) ready_cnt[i]++;
      if (add_start === 1'b1) start_cnt++;
      if (!m_busy) begin
        m_g = pick(req_valid, m_ptr);
        chk("req_ready",       32'(req_ready),  32'(m_g));
        chk("add_start_idle",  32'(add_start),  32'(0));
        chk("resp_valid_idle", 32'(resp_valid), 32'(0));
        if (m_g != '0) begin
          for (int i = 0; i < NREQ; i++) if (m_g[i]) m_owner = i;
          m_a    = req_a[m_owner];
          m_b    = req_b[m_owner];
          m_busy = 1'b1;
          m_pend = 1'b0;
          m_age  = 0;
        end
      end else begin
        m_age++;
        chk("req_ready_busy", 32'(req_ready), 32'(0));
        if (m_pend) begin
          chk("resp_valid", 32'(resp_valid), 32'(1));
          chk("resp_id",    32'(resp_id),    32'(m_owner));
          chk("resp_sum",   resp_sum,        m_sum);
          chk("resp_err",   32'(resp_err),   32'(m_err));
          chk("add_start_resp", 32'(add_start), 32'(0));
          q_id.push_back(m_owner);
          q_sum.push_back(resp_sum);
          q_err.push_back(resp_err);
          q_lat.push_back(m_age);
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NREQ;
        end else begin
          chk("resp_valid_busy", 32'(resp_valid), 32'(0));
          chk("add_start",       32'(add_start),  32'(m_age == 1));
          chk("add_a", add_a, m_a);
          chk("add_b", add_b, m_b);
          if (m_age >= 2) begin
            if (add_done_m === 1'b1) begin
              m_pend = 1'b1;
              m_sum  = add_sum_m;
              m_err  = 1'b0;
            end else if (m_age == TIMEOUT + 1) begin
              m_pend = 1'b1;
              m_sum  = QNAN;
              m_err  = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic present(input int i, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_a[i]     = a;
    req_b[i]     = b;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (req_ready[i] === 1'b1) begin
        checks++;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_%0d: req_ready never rose, required within 600 cycles", i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resps(input int n, input int bound);
    for (int t = 0; t < bound; t++) begin
      if (q_id.size() >= n) return;
      @(negedge clk); #1;
    end
    checks++;
    if (q_id.size() < n) begin
      errors++;
      $display("FAIL resp_wait: got %0d responses, required %0d", q_id.size(), n);
    end
  endtask

  task automatic chk_resp(input int k, input int id, input logic [31:0] sum, input bit err,
                          input int lat);
    if (k >= q_id.size()) begin
      checks++;
      errors++;
      $display("FAIL resp%0d_missing: got %0d responses, required %0d", k, q_id.size(), k + 1);
      return;
    end
    chk($sformatf("resp%0d_id", k),  32'(q_id[k]),  32'(id));
    chk($sformatf("resp%0d_sum", k), q_sum[k],      sum);
    chk($sformatf("resp%0d_err", k), 32'(q_err[k]), 32'(err));
    chk($sformatf("resp%0d_lat", k), 32'(q_lat[k]), 32'(lat));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // ---------------- directed scenarios
  initial begin
    int n;
    int fair_ids[6];
    fair_ids = '{0, 1, 2, 3, 0, 1};

    // Reset held with requests pending: nothing may be accepted.
    req_valid = 4'b0101;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'(0));
    chk("reset_resp_id",   32'(resp_id),   32'(0));
    chk("reset_resp_sum",  resp_sum,       32'(0));
    chk("reset_add_b",     add_b,          32'(0));
    req_valid = '0;
    @(posedge clk);
    #2 reset = 1'b0;

    // Single request from requester 2 with a stale done left high from before reset.
    present(2, 32'h3F80_0000, 32'h4000_0000);
    wait_resps(1, 100);
    chk_resp(0, 2, 32'h4040_0000, 1'b0, 5);
    chk("single_ready_cycles", 32'(ready_cnt[2]), 32'(1));
    chk("single_start_pulses", 32'(start_cnt),    32'(1));

    // Fairness: all requesters held valid from reset.
    do_reset();
    n = q_id.size();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'h4100_0000 + 32'(i);
      req_b[i] = 32'h0000_0100 * 32'(i + 1);
    end
    req_valid = '1;
    wait_resps(n + 6, 200);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      if (n + k < q_id.size()) chk($sformatf("fair%0d_id", k), 32'(q_id[n + k]), 32'(fair_ids[k]));
      else chk($sformatf("fair%0d_missing", k), 32'(q_id.size()), 32'(n + k + 1));
    end

    // Stuck adder: watchdog returns qNaN with err after TIMEOUT wait cycles.
    n = q_id.size();
    a_stuck = 1'b1;
    present(1, 32'h4040_0000, 32'h3F80_0000);
    wait_resps(n + 1, 400);
    chk_resp(n, 1, QNAN, 1'b1, TIMEOUT + 2);
    a_stuck = 1'b0;

    // Recovery after timeout, zero operand.
    present(1, 32'h0000_0000, 32'hC0A0_0000);
    wait_resps(n + 2, 100);
    chk_resp(n + 1, 1, 32'hC0A0_0000, 1'b0, 5);

    // Stale done high through IDLE/ISSUE; infinity operand.
    present(3, 32'h7F80_0000, 32'h3F80_0000);
    wait_resps(n + 3, 100);
    chk_resp(n + 2, 3, 32'h7F80_0000, 1'b0, 5);

    // Requester 0 leaves the pointer at 1.
    present(0, 32'h3F80_0000, 32'h4000_0000);
    wait_resps(n + 4, 100);
    chk_resp(n + 3, 0, 32'h4040_0000, 1'b0, 5);

    // Reset asserted mid-WAIT, between clock edges.
    a_lat = 50;
    present(3, 32'h4120_0000, 32'h4120_0000);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'(0));
    chk("midrst_resp_id",    32'(resp_id),    32'(0));
    chk("midrst_resp_sum",   resp_sum,        32'(0));
    chk("midrst_resp_err",   32'(resp_err),   32'(0));
    chk("midrst_add_start",  32'(add_start),  32'(0));
    chk("midrst_add_a",      add_a,           32'(0));
    chk("midrst_add_b",      add_b,           32'(0));
    n = q_id.size();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    a_lat = 4;
    @(posedge clk); #1;
    chk("midrst_no_resp", 32'(q_id.size()), 32'(n));
    req_a[0]  = 32'h0000_0000;
    req_b[0]  = 32'hC0A0_0000;
    req_a[1]  = 32'h3F80_0000;
    req_b[1]  = 32'h3F80_0000;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("post_reset_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    wait_resps(n + 1, 100);
    chk_resp(n, 0, 32'hC0A0_0000, 1'b0, 6);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: simulation still running at 500000 ns, required to end earlier");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fpadd_sched.md
# fpadd_sched

Round-robin scheduler sharing one multi-cycle `fpadd` single-precision adder between `NREQ` requesters. It accepts one operand pair at a time, pulses the adder's `start`, waits for `done`, and returns the sum to the owning requester with an id tag. A watchdog bounds the wait and returns an error result if the adder never finishes. It sits between the client blocks and the single adder instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 320: maximum cycles waited for `add_done` after `add_start`.
- `clk` in 1: the only clock; all logic updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in `NREQ`: bit i is high when requester i has an operand pair.
- `req_a`, `req_b` in `NREQ*32`: operands; requester i uses bits `[32i+31:32i]`.
- `req_ready` out `NREQ`: one-hot accept; the transfer happens when `req_valid[i] & req_ready[i]`.
- `resp_valid` out 1: one-cycle pulse carrying the result.
- `resp_id` out `$clog2(NREQ)`: requester that owns the response.
- `resp_sum` out 32: IEEE-754 single result.
- `resp_err` out 1: high when the watchdog expired.
- `add_start` out 1: one-cycle start pulse to the adder.
- `add_a`, `add_b` out 32: adder operands.
- `add_sum` in 32: adder result.
- `add_done` in 1: adder completion level.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, the round-robin picker selects the winner w, searching upward from `rr_ptr` with wrap.
  - `req_ready[w]` is driven high combinationally in the same cycle.
  - On the edge: latch `req_a[w]`/`req_b[w]` into the operand registers and w into `owner`, then go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - `add_start=1` for exactly this cycle; `add_a`/`add_b` come from the operand registers.
  - Clear the watchdog counter, then go to WAIT.
- **WAIT**
  - `add_a`/`add_b` stay stable. The counter increments every cycle.
  - If `add_done=1`: latch `add_sum`, set err=0, go to RESP.
  - Else if counter equals `TIMEOUT-1`: latch the sum as `32'h7FC00000`, set err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - `resp_valid=1` with `resp_id=owner`, `resp_sum` and `resp_err` valid.
  - Set `rr_ptr <= (owner+1) mod NREQ`, then go to IDLE.
- `add_done` is ignored outside WAIT. Its stale high level from the previous operation, and an unknown value after reset, are both harmless: the adder clears `done` at its `start` edge, so `done` is already low on the first WAIT cycle.
- Requesters hold `req_valid`/`req_a`/`req_b` until accepted; a requester that deasserts valid before acceptance simply loses its slot.
- Responses have no backpressure; clients must sink `resp_valid` on every cycle.
- After a timeout the adder may still be running. The next ISSUE `start` restarts it, because the adder's `start` overrides its state machine.

## Timing
- Reset values:
  - Outputs: `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_sum=0`, `resp_err=0`, `add_start=0`, `add_a=0`, `add_b=0`.
  - Internal: state=IDLE, `rr_ptr=0`, counter=0.
- Latency from accept edge to `resp_valid` = 2 + D cycles, where D is the number of WAIT cycles up to and including the one where `add_done` is seen. One operation is in flight at a time.
- Back-to-back operations: the next acceptance occurs in the IDLE cycle after RESP, so the overhead is 3 cycles per operation (IDLE, ISSUE, RESP).
- Reset asserted in any state forces the reset values immediately and drops the in-flight operation with no response. The first post-reset ISSUE re-initialises the adder.
- `TIMEOUT` default of 320 exceeds the adder worst case: about 255 alignment cycles + 24 normalisation cycles + fixed states.

## Structure
- `fpadd_pkg` holds:
  - the state enumeration `sched_state_t` (IDLE, ISSUE, WAIT, RESP);
  - `FP_QNAN = 32'h7FC00000`;
  - `FPADD_TIMEOUT_DEF = 320`.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and the pointer; outputs are the one-hot grant, the binary index, and an any-request flag. It is parameterised by `NREQ` and is reusable by other shared units.
- `fpadd_sched` contains the FSM, operand/result registers, pointer and watchdog. It instantiates `rr_pick` once. The adder itself is instantiated outside this block.

## Test plan
- **Single request.** Requester 2 presents a=`3F800000` (1.0), b=`40000000` (2.0).
  - `req_ready[2]` is high for 1 cycle and `add_start` for 1 cycle.
  - Response: `resp_id=2`, `resp_sum=40400000`, `resp_err=0`.
- **Fairness.** All 4 requesters are held valid continuously after reset.
  - Grant order is 0,1,2,3,0,1…, with exactly one response per grant and ids matching.
- **Stuck adder.** The adder model never raises `done`.
  - After `TIMEOUT` WAIT cycles: `resp_sum=7FC00000`, `resp_err=1`.
  - The next request then completes normally.
- **Stale done.** `add_done` is held high by the model from before ISSUE.
  - Only a `done` seen while in WAIT completes the operation; no early response, `resp_sum` is the new value.
- **Reset mid-WAIT.** Assert `reset` asynchronously during WAIT.
  - All outputs drop to reset values without waiting for a clock edge; no `resp_valid`.
  - The next grant goes to requester 0.
- **Zero and infinity operands.** a=`00000000`, b=`C0A00000` → `resp_sum=C0A00000`; a=`7F800000`, b=`3F800000` → `resp_sum=7F800000`.
